// File: rtl/irq_pkg.sv
// Shared constants for the interrupt flag controller: bus address of IF,
// source bit positions and the default number of implemented sources.
package irq_pkg;

    localparam int          NUM_SRC_DEFAULT = 5;
    localparam logic [15:0] IF_ADDR_DEFAULT = 16'hFF0F;

    typedef enum logic [2:0] {
        IRQ_VBLANK = 3'd0,
        IRQ_STAT   = 3'd1,
        IRQ_TIMER  = 3'd2,
        IRQ_SERIAL = 3'd3,
        IRQ_JOYPAD = 3'd4
    } irq_src_e;

endpackage

// File: rtl/irq_flag_ctrl_if.sv
// CPU bus, peripheral request and CPU IRQ handshake signals of the flag controller.
// The master side is the CPU/peripheral world, the slave side is irq_flag_ctrl.
interface irq_flag_ctrl_if
    import irq_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEFAULT
);

    logic [15:0]        A;
    logic [7:0]         D_IN;
    logic [7:0]         D_OUT;
    logic               D_OE;
    logic               RD;
    logic               WR;
    logic [NUM_SRC-1:0] PERIPH_IRQ;
    logic [7:0]         CPU_IRQ_ACK;
    logic [7:0]         CPU_IRQ_TRIG;

    modport master (
        output A, D_IN, RD, WR, PERIPH_IRQ, CPU_IRQ_ACK,
        input  D_OUT, D_OE, CPU_IRQ_TRIG
    );

    modport slave (
        input  A, D_IN, RD, WR, PERIPH_IRQ, CPU_IRQ_ACK,
        output D_OUT, D_OE, CPU_IRQ_TRIG
    );

endinterface

// File: rtl/irq_edge_det.sv
// Vector rising-edge detector. History resets to all ones so a line that is
// already high when reset is released does not produce an event.
module irq_edge_det
    import irq_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             CLK,
    input  logic             SYNC_RES,
    input  logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] hist;

    always_ff @(posedge CLK) begin
        if (SYNC_RES) begin
            hist <= '1;
        end else begin
            hist <= sig;
        end
    end

    assign rise = sig & ~hist;

endmodule

// File: rtl/irq_flag_ctrl.sv
// Interrupt flag (IF) register: latches peripheral request edges, supports
// CPU read/write at IF_ADDR and per-bit clear by CPU acknowledge edges.
module irq_flag_ctrl
    import irq_pkg::*;
#(
    parameter int          NUM_SRC = NUM_SRC_DEFAULT,
    parameter logic [15:0] IF_ADDR = IF_ADDR_DEFAULT
) (
    input  logic             CLK,
    input  logic             SYNC_RES,
    irq_flag_ctrl_if.slave   bus
);

    logic [NUM_SRC-1:0] flags;
    logic [NUM_SRC-1:0] flags_nxt;
    logic [NUM_SRC-1:0] irq_rise;
    logic [NUM_SRC-1:0] ack_clr;
    logic [7:0]         ack_rise;
    logic [0:0]         wr_rise;
    logic               addr_hit;
    logic               wr_hit;
    logic               rd_hit;
    logic [7:0]         trig_val;
    logic [7:0]         rd_val;
    logic               unused_bits;

    irq_edge_det #(.WIDTH(NUM_SRC)) u_req_edge (
        .CLK      (CLK),
        .SYNC_RES (SYNC_RES),
        .sig      (bus.PERIPH_IRQ),
        .rise     (irq_rise)
    );

    irq_edge_det #(.WIDTH(8)) u_ack_edge (
        .CLK      (CLK),
        .SYNC_RES (SYNC_RES),
        .sig      (bus.CPU_IRQ_ACK),
        .rise     (ack_rise)
    );

    irq_edge_det #(.WIDTH(1)) u_wr_edge (
        .CLK      (CLK),
        .SYNC_RES (SYNC_RES),
        .sig      (bus.WR),
        .rise     (wr_rise)
    );

    assign addr_hit = (bus.A == IF_ADDR);
    assign wr_hit   = wr_rise[0] && addr_hit;
    assign rd_hit   = bus.RD && addr_hit;
    assign ack_clr  = ack_rise[NUM_SRC-1:0];

    // Later assignments win: write overrides hold, ack overrides write,
    // and a fresh request edge overrides everything.
    always_comb begin
        flags_nxt = flags;
        if (wr_hit) begin
            flags_nxt = bus.D_IN[NUM_SRC-1:0];
        end
        flags_nxt = (flags_nxt & ~ack_clr) | irq_rise;
    end

    always_ff @(posedge CLK) begin
        if (SYNC_RES) begin
            flags <= '0;
        end else begin
            flags <= flags_nxt;
        end
    end

    always_comb begin
        trig_val              = '0;
        trig_val[NUM_SRC-1:0] = flags;
        rd_val                = '1;
        rd_val[NUM_SRC-1:0]   = flags;
    end

    assign bus.CPU_IRQ_TRIG = trig_val;
    assign bus.D_OE         = rd_hit;
    assign bus.D_OUT        = rd_hit ? rd_val : 8'h00;

    // Upper data and ack bits only exist for bus width; they carry no state.
    assign unused_bits = ^{bus.D_IN, ack_rise};

endmodule

// File: tb/tb_irq_flag_ctrl.sv
// Directed self-checking bench for irq_flag_ctrl with hand-computed expectations.
module tb_irq_flag_ctrl;
    import irq_pkg::*;

    logic CLK;
    logic SYNC_RES;
    int   checks;
    int   failures;

    irq_flag_ctrl_if #(.NUM_SRC(5)) bus ();

    irq_flag_ctrl #(.NUM_SRC(5), .IF_ADDR(16'hFF0F)) dut (
        .CLK      (CLK),
        .SYNC_RES (SYNC_RES),
        .bus      (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_read(input logic [15:0] addr, output logic [7:0] data, output logic oe);
        bus.A  = addr;
        bus.RD = 1'b1;
        #1;
        data   = bus.D_OUT;
        oe     = bus.D_OE;
        bus.RD = 1'b0;
        bus.A  = 16'h0000;
        #1;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
        bus.A    = addr;
        bus.D_IN = data;
        bus.WR   = 1'b1;
        tick();
        bus.WR   = 1'b0;
        bus.A    = 16'h0000;
        bus.D_IN = 8'h00;
        tick();
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic       oe;
        SYNC_RES        = 1'b1;
        bus.PERIPH_IRQ  = 5'b00001;
        repeat (3) tick();
        checks++;
        if (bus.CPU_IRQ_TRIG !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_trig: got %h want 00", bus.CPU_IRQ_TRIG);
        end
        do_read(16'hFF0F, d, oe);
        checks++;
        if (d !== 8'hE0 || oe !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_read: got %h/%b want e0/1", d, oe);
        end
        SYNC_RES = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.CPU_IRQ_TRIG !== 8'h00) begin
            failures++;
            $display("[TB] FAIL release_trig: got %h want 00", bus.CPU_IRQ_TRIG);
        end
        do_read(16'hFF0F, d, oe);
        checks++;
        if (d !== 8'hE0 || oe !== 1'b1) begin
            failures++;
            $display("[TB] FAIL release_read: got %h/%b want e0/1", d, oe);
        end
        bus.PERIPH_IRQ = 5'b00000;
        tick();
    endtask

    task automatic test_request_ack();
        logic [7:0] d;
        logic       oe;
        bus.PERIPH_IRQ[IRQ_TIMER] = 1'b1;
        #1;
        checks++;
        if (bus.CPU_IRQ_TRIG !== 8'h00) begin
            failures++;
            $display("[TB] FAIL req_no_comb: got %h want 00", bus.CPU_IRQ_TRIG);
        end
        tick();
        checks++;
        if (bus.CPU_IRQ_TRIG !== 8'h04) begin
            failures++;
            $display("[TB] FAIL req_set: got %h want 04", bus.CPU_IRQ_TRIG);
        end
        do_read(16'hFF0F, d, oe);
        checks++;
        if (d !== 8'hE4) begin
            failures++;
            $display("[TB] FAIL req_read: got %h want e4", d);
        end
        bus.CPU_IRQ_ACK = 8'h04;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.CPU_IRQ_TRIG !== 8'h00) begin
                failures++;
                $display("[TB] FAIL ack_held_%0d: got %h want 00", i, bus.CPU_IRQ_TRIG);
            end
        end
        bus.CPU_IRQ_ACK = 8'h00;
        repeat (2) tick();
        checks++;
        if (bus.CPU_IRQ_TRIG !== 8'h00) begin
            failures++;
            $display("[TB] FAIL level_no_reset: got %h want 00", bus.CPU_IRQ_TRIG);
        end
        bus.PERIPH_IRQ = 5'b00000;
        tick();
    endtask

    task automatic test_write_read();
        logic [7:0] d;
        logic       oe;
        do_write(16'hFF0F, 8'hFF);
        do_read(16'hFF0F, d, oe);
        checks++;
        if (bus.CPU_IRQ_TRIG !== 8'h1F || d !== 8'hFF || oe !== 1'b1) begin
            failures++;
            $display("[TB] FAIL write_ff: got trig %h read %h oe %b want 1f ff 1", bus.CPU_IRQ_TRIG, d, oe);
        end
        do_write(16'hFF0F, 8'hA5);
        do_read(16'hFF0F, d, oe);
        checks++;
        if (bus.CPU_IRQ_TRIG !== 8'h05 || d !== 8'hE5) begin
            failures++;
            $display("[TB] FAIL write_a5: got trig %h read %h want 05 e5", bus.CPU_IRQ_TRIG, d);
        end
        do_write(16'hFF0F, 8'h00);
        do_read(16'hFF0F, d, oe);
        checks++;
        if (bus.CPU_IRQ_TRIG !== 8'h00 || d !== 8'hE0) begin
            failures++;
            $display("[TB] FAIL write_00: got trig %h read %h want 00 e0", bus.CPU_IRQ_TRIG, d);
        end
    endtask

    task automatic test_ack_vs_request();
        do_write(16'hFF0F, 8'h01);
        bus.CPU_IRQ_ACK            = 8'h01;
        bus.PERIPH_IRQ[IRQ_VBLANK] = 1'b1;
        tick();
        checks++;
        if (bus.CPU_IRQ_TRIG !== 8'h01) begin
            failures++;
            $display("[TB] FAIL ack_vs_req: got %h want 01", bus.CPU_IRQ_TRIG);
        end
        bus.CPU_IRQ_ACK = 8'h00;
        bus.PERIPH_IRQ  = 5'b00000;
        tick();
        do_write(16'hFF0F, 8'h1F);
        bus.CPU_IRQ_ACK = 8'hE3;
        tick();
        bus.CPU_IRQ_ACK = 8'h00;
        tick();
        checks++;
        if (bus.CPU_IRQ_TRIG !== 8'h1C) begin
            failures++;
            $display("[TB] FAIL ack_multi: got %h want 1c", bus.CPU_IRQ_TRIG);
        end
        bus.CPU_IRQ_ACK = 8'h80;
        tick();
        bus.CPU_IRQ_ACK = 8'h00;
        tick();
        checks++;
        if (bus.CPU_IRQ_TRIG !== 8'h1C) begin
            failures++;
            $display("[TB] FAIL ack_unimpl: got %h want 1c", bus.CPU_IRQ_TRIG);
        end
    endtask

    task automatic test_write_vs_request();
        bus.A                      = 16'hFF0F;
        bus.D_IN                   = 8'h00;
        bus.WR                     = 1'b1;
        bus.PERIPH_IRQ[IRQ_SERIAL] = 1'b1;
        tick();
        bus.WR = 1'b0;
        checks++;
        if (bus.CPU_IRQ_TRIG !== 8'h08) begin
            failures++;
            $display("[TB] FAIL write_vs_req: got %h want 08", bus.CPU_IRQ_TRIG);
        end
        tick();
        do_write(16'hFF0F, 8'h00);
        checks++;
        if (bus.CPU_IRQ_TRIG !== 8'h00) begin
            failures++;
            $display("[TB] FAIL write_clear_held: got %h want 00", bus.CPU_IRQ_TRIG);
        end
        bus.PERIPH_IRQ = 5'b00000;
        tick();
    endtask

    task automatic test_miss_and_reset();
        logic [7:0] d;
        logic       oe;
        do_write(16'hFF0F, 8'h1F);
        do_write(16'hFF0E, 8'h00);
        checks++;
        if (bus.CPU_IRQ_TRIG !== 8'h1F) begin
            failures++;
            $display("[TB] FAIL write_miss: got %h want 1f", bus.CPU_IRQ_TRIG);
        end
        bus.WR = 1'b1;
        bus.A  = 16'hFF0E;
        #1;
        checks++;
        if (bus.D_OE !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wr_no_oe: got %b want 0", bus.D_OE);
        end
        bus.WR = 1'b0;
        tick();
        do_read(16'hFF0E, d, oe);
        checks++;
        if (d !== 8'h00 || oe !== 1'b0) begin
            failures++;
            $display("[TB] FAIL read_miss: got %h/%b want 00/0", d, oe);
        end
        SYNC_RES       = 1'b1;
        bus.A          = 16'hFF0F;
        bus.D_IN       = 8'hFF;
        bus.WR         = 1'b1;
        bus.PERIPH_IRQ = 5'h1F;
        tick();
        checks++;
        if (bus.CPU_IRQ_TRIG !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_dominates: got %h want 00", bus.CPU_IRQ_TRIG);
        end
        SYNC_RES = 1'b0;
        bus.WR   = 1'b0;
        bus.A    = 16'h0000;
        tick();
        tick();
        checks++;
        if (bus.CPU_IRQ_TRIG !== 8'h00) begin
            failures++;
            $display("[TB] FAIL no_spurious_after_reset: got %h want 00", bus.CPU_IRQ_TRIG);
        end
        bus.PERIPH_IRQ = 5'b00000;
        tick();
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        SYNC_RES        = 1'b1;
        bus.A           = 16'h0000;
        bus.D_IN        = 8'h00;
        bus.RD          = 1'b0;
        bus.WR          = 1'b0;
        bus.PERIPH_IRQ  = 5'b00000;
        bus.CPU_IRQ_ACK = 8'h00;
        test_reset();
        test_request_ack();
        test_write_read();
        test_ack_vs_request();
        test_write_vs_request();
        test_miss_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_flag_ctrl.md
IRQ_FLAG_CTRL -- requirements
Module: irq_flag_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 5, count of implemented peripheral request sources; bits 7:NUM_SRC of IF are unimplemented.
REQ-002 Parameter IF_ADDR, default 16'hFF0F, bus address of the IF register.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SYNC_RES  input  1  synchronous, active-high reset, sampled on CLK rising edge.
REQ-005 A  input  16  CPU address bus.
REQ-006 D_IN  input  8  CPU write data.
REQ-007 D_OUT  output  8  read data, valid while D_OE=1, otherwise 8'h00.
REQ-008 D_OE  output  1  read-drive enable.
REQ-009 RD  input  1  CPU read strobe, level.
REQ-010 WR  input  1  CPU write strobe, level; one write per WR rising edge.
REQ-011 PERIPH_IRQ  input  NUM_SRC  peripheral requests: bit0 VBlank, bit1 STAT, bit2 Timer, bit3 Serial, bit4 Joypad; level signals, rising edge = event.
REQ-012 CPU_IRQ_ACK  input  8  one-hot acknowledge from the CPU IRQ logic; may be held high for several cycles.
REQ-013 CPU_IRQ_TRIG  output  8  pending flags presented to the CPU IRQ logic (the CPU applies IE masking).

Function
REQ-014 Block SHALL hold IF register flags[NUM_SRC-1:0].
REQ-015 Request: rising edge of PERIPH_IRQ[i] (previous-cycle 0, current 1) SHALL set flags[i] at the next CLK edge, i.e. 1-cycle latency from the edge being sampled.
REQ-016 A level held high SHALL NOT re-set a flag cleared by write or ack; only a new 0->1 transition sets it.
REQ-017 Write hit: WR rising edge with A==IF_ADDR SHALL load flags <= D_IN[NUM_SRC-1:0]; D_IN[7:NUM_SRC] ignored.
REQ-018 Ack: rising edge of CPU_IRQ_ACK[i], i<NUM_SRC, SHALL clear flags[i] once; a held ack SHALL NOT clear again.
REQ-019 Ack on bit i>=NUM_SRC, or non-one-hot ack edge, SHALL clear every corresponding implemented bit and otherwise be ignored.
REQ-020 Per-bit update priority, lowest to highest: hold, write, ack clear, request set; a request edge in the same cycle as a write or ack of that bit leaves the bit set.
REQ-021 CPU_IRQ_TRIG[NUM_SRC-1:0] SHALL equal flags registered (no combinational path from PERIPH_IRQ); CPU_IRQ_TRIG[7:NUM_SRC] SHALL be 0.
REQ-022 Read: RD=1 and A==IF_ADDR SHALL assert D_OE combinationally and drive D_OUT = {unimplemented bits as 1, flags}; default NUM_SRC=5 gives 8'hE0|flags.
REQ-023 Read data SHALL reflect flags as registered at start of the cycle; a same-cycle set is visible next cycle.
REQ-024 Write and read strobes with A!=IF_ADDR SHALL have no effect and D_OE=0.

Reset
REQ-025 While SYNC_RES=1: flags=0, all edge-detector history registers=1 (no spurious event from a line already high at reset release), WR history=1.
REQ-026 Outputs under reset: CPU_IRQ_TRIG=8'h00; D_OUT/D_OE follow REQ-022 with flags=0.
REQ-027 Reset mid-operation SHALL discard pending requests, acks and writes in that cycle; SYNC_RES dominates all REQ-020 sources.

Structure
REQ-028 Shared package irq_pkg SHALL hold IF_ADDR default, source bit indices (IRQ_VBLANK..IRQ_JOYPAD), and NUM_SRC default.
REQ-029 One sub-module irq_edge_det (vector rising-edge detector, parameterised width, reset-to-1 history) SHALL be used for PERIPH_IRQ, CPU_IRQ_ACK and WR.
REQ-030 No latches, no multiple clocks; all logic synchronous to CLK.

Verification
REQ-031 Reset, PERIPH_IRQ=5'b00001 held through reset release -> flags stay 0, CPU_IRQ_TRIG=8'h00; read IF -> 8'hE0.
REQ-032 PERIPH_IRQ[2] 0->1 at cycle n -> CPU_IRQ_TRIG=8'h04 from cycle n+1; ack 8'h04 held 3 cycles -> TRIG=8'h00 after first ack cycle, stays 0 while PERIPH_IRQ[2] held high.
REQ-033 Write 8'hFF to FF0F -> TRIG=8'h1F, read 8'hFF; write 8'h00 -> TRIG=8'h00, read 8'hE0.
REQ-034 Same cycle: ack 8'h01 edge and PERIPH_IRQ[0] edge with flag0=1 -> flag0 remains 1.
REQ-035 Same cycle: write 8'h00 and PERIPH_IRQ[3] edge -> TRIG=8'h08.
REQ-036 Write 8'h1F to FF0E and read FF0E -> flags unchanged, D_OE=0; SYNC_RES pulse with flags=8'h1F -> TRIG=8'h00 next cycle.
